// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle sequencer for the 68030 glue logic: per-region wait-state DTACK generation,
// pass-through of slow-device DTACK, and a watchdog that raises BERR on unanswered cycles.
module bus_cycle_ctrl #(
  parameter int unsigned ROM_WS   = 2,
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned EXP_WS   = 4,
  parameter int unsigned WD_LIMIT = 127
) (
  input  logic       CLK,
  input  logic       HWRST,
  input  logic       ASn,
  input  logic [2:0] FC,
  input  logic       ROMSELn,
  input  logic       RAMSELn,
  input  logic       EXPSELn,
  input  logic       IOSELn,
  input  logic       EXTDTACKn,
  output logic       DTACK_OE,
  output logic       BERR_OE,
  output logic       BUSY,
  output logic [7:0] BERRCNT
);

  localparam logic [3:0] RomWs   = 4'(ROM_WS);
  localparam logic [3:0] RamWs   = 4'(RAM_WS);
  localparam logic [3:0] ExpWs   = 4'(EXP_WS);
  localparam logic [7:0] WdLimit = 8'(WD_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StExtw,
    StAck,
    StBerr
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] berrcnt_q, berrcnt_d;
  logic       dtack_oe_q, dtack_oe_d;
  logic       berr_oe_q, berr_oe_d;
  logic       busy_q, busy_d;

  logic       mem_sel;
  logic [3:0] mem_ws;
  logic [7:0] wd_inc;

  // Region priority ROM > RAM > EXP; IO and unmapped both fall through to EXTW.
  always_comb begin
    mem_sel = 1'b1;
    mem_ws  = 4'd0;
    if (!ROMSELn) begin
      mem_ws = RomWs;
    end else if (!RAMSELn) begin
      mem_ws = RamWs;
    end else if (!EXPSELn) begin
      mem_ws = ExpWs;
    end else begin
      mem_sel = 1'b0;
    end
  end

  assign wd_inc = wd_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wd_d      = wd_q;
    berrcnt_d = berrcnt_q;
    unique case (state_q)
      StIdle: begin
        if (!ASn) begin
          if (FC != 3'b111 && mem_sel) begin
            wcnt_d  = mem_ws;
            state_d = (mem_ws == 4'd0) ? StAck : StWait;
          end else begin
            wd_d    = 8'd0;
            state_d = StExtw;
          end
        end
      end
      StWait: begin
        if (ASn) begin
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = StAck;
        end
      end
      StExtw: begin
        if (ASn) begin
          state_d = StIdle;
        end else begin
          wd_d = wd_inc;
          // A device acknowledge beats a watchdog expiry on the same edge.
          if (!EXTDTACKn) begin
            state_d = StAck;
          end else if (wd_inc == WdLimit) begin
            state_d = StBerr;
          end
        end
      end
      StAck: begin
        if (ASn) state_d = StIdle;
      end
      StBerr: begin
        if (ASn) begin
          state_d = StIdle;
          if (berrcnt_q != 8'hff) berrcnt_d = berrcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dtack_oe_d = (state_d == StAck);
    berr_oe_d  = (state_d == StBerr);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge CLK or posedge HWRST) begin
    if (HWRST) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      wd_q       <= 8'd0;
      berrcnt_q  <= 8'd0;
      dtack_oe_q <= 1'b0;
      berr_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wd_q       <= wd_d;
      berrcnt_q  <= berrcnt_d;
      dtack_oe_q <= dtack_oe_d;
      berr_oe_q  <= berr_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign DTACK_OE = dtack_oe_q;
  assign BERR_OE  = berr_oe_q;
  assign BUSY     = busy_q;
  assign BERRCNT  = berrcnt_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with default parameters (ROM 2, RAM 0, EXP 4, WD 127).
module tb_bus_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       HWRST;
  logic       ASn;
  logic [2:0] FC;
  logic       ROMSELn, RAMSELn, EXPSELn, IOSELn, EXTDTACKn;
  logic       DTACK_OE, BERR_OE, BUSY;
  logic [7:0] BERRCNT;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  bus_cycle_ctrl dut (
    .CLK      (CLK),
    .HWRST    (HWRST),
    .ASn      (ASn),
    .FC       (FC),
    .ROMSELn  (ROMSELn),
    .RAMSELn  (RAMSELn),
    .EXPSELn  (EXPSELn),
    .IOSELn   (IOSELn),
    .EXTDTACKn(EXTDTACKn),
    .DTACK_OE (DTACK_OE),
    .BERR_OE  (BERR_OE),
    .BUSY     (BUSY),
    .BERRCNT  (BERRCNT)
  );

  always #5 CLK = ~CLK;

  // Each tick is one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    ASn = 1'b1; FC = 3'b101;
    ROMSELn = 1'b1; RAMSELn = 1'b1; EXPSELn = 1'b1; IOSELn = 1'b1;
    EXTDTACKn = 1'b1;
  endtask

  task automatic test_reset();
    bus_idle();
    HWRST = 1'b1;
    tick(); tick();
    total++;
    if ({DTACK_OE, BERR_OE, BUSY} !== 3'b000 || BERRCNT !== 8'd0) begin
      bad++; $display("FAIL reset_state: got dt=%b be=%b busy=%b cnt=%0d want 0 0 0 0",
                      DTACK_OE, BERR_OE, BUSY, BERRCNT);
    end
    HWRST = 1'b0;
    tick();
    ASn = 1'b0; ROMSELn = 1'b0;
    tick(); // k
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL reset_busy_k: got %b want 1", BUSY); end
    tick(); // k+1, in WAIT
    #2 HWRST = 1'b1;
    #1;
    total++;
    if ({DTACK_OE, BERR_OE, BUSY} !== 3'b000 || BERRCNT !== 8'd0) begin
      bad++; $display("FAIL reset_async: got dt=%b be=%b busy=%b cnt=%0d want 0 0 0 0",
                      DTACK_OE, BERR_OE, BUSY, BERRCNT);
    end
    bus_idle();
    #2 HWRST = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({DTACK_OE, BUSY} !== 2'b00) begin
      bad++; $display("FAIL reset_release_idle: got dt=%b busy=%b want 0 0", DTACK_OE, BUSY);
    end
  endtask

  task automatic test_ram();
    ASn = 1'b0; RAMSELn = 1'b0;
    tick(); // k
    total++;
    if (DTACK_OE !== 1'b1) begin bad++; $display("FAIL ram_dtack_k: got %b want 1", DTACK_OE); end
    bus_idle();
    tick();
    total++;
    if ({DTACK_OE, BUSY} !== 2'b00) begin
      bad++; $display("FAIL ram_release: got dt=%b busy=%b want 0 0", DTACK_OE, BUSY);
    end
  endtask

  task automatic test_rom();
    ASn = 1'b0; ROMSELn = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick(); // k+e
      total++;
      if (DTACK_OE !== (e >= 2)) begin
        bad++; $display("FAIL rom_dtack_k+%0d: got %b want %b", e, DTACK_OE, (e >= 2));
      end
    end
    bus_idle();
    tick(); // k+5
    total++;
    if ({DTACK_OE, BUSY} !== 2'b00) begin
      bad++; $display("FAIL rom_release_k+5: got dt=%b busy=%b want 0 0", DTACK_OE, BUSY);
    end
  endtask

  task automatic test_io();
    ASn = 1'b0; IOSELn = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      total++;
      if (DTACK_OE !== 1'b0 || BUSY !== 1'b1) begin
        bad++; $display("FAIL io_wait_k+%0d: got dt=%b busy=%b want 0 1", e, DTACK_OE, BUSY);
      end
    end
    EXTDTACKn = 1'b0;
    tick(); // k+6
    total++;
    if ({DTACK_OE, BERR_OE} !== 2'b10 || BERRCNT !== 8'(exp_cnt)) begin
      bad++; $display("FAIL io_ack_k+6: got dt=%b be=%b cnt=%0d want 1 0 %0d",
                      DTACK_OE, BERR_OE, BERRCNT, exp_cnt);
    end
    bus_idle();
    tick();
    total++;
    if ({DTACK_OE, BUSY} !== 2'b00) begin
      bad++; $display("FAIL io_release: got dt=%b busy=%b want 0 0", DTACK_OE, BUSY);
    end
  endtask

  // Interrupt acknowledge ignores a RAM select and waits for the device.
  task automatic test_iack();
    ASn = 1'b0; FC = 3'b111; RAMSELn = 1'b0;
    tick(); // k
    total++;
    if (DTACK_OE !== 1'b0) begin bad++; $display("FAIL iack_k: got %b want 0", DTACK_OE); end
    tick(); // k+1
    EXTDTACKn = 1'b0;
    tick(); // k+2
    total++;
    if (DTACK_OE !== 1'b1) begin bad++; $display("FAIL iack_k+2: got %b want 1", DTACK_OE); end
    bus_idle();
    tick();
  endtask

  task automatic test_simultaneous();
    int early = 0;
    ASn = 1'b0; IOSELn = 1'b0;
    for (int e = 0; e < 127; e++) begin
      tick();
      if (DTACK_OE !== 1'b0 || BERR_OE !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL simul_early: got %0d early edges want 0", early); end
    EXTDTACKn = 1'b0;
    tick(); // k+127
    total++;
    if ({DTACK_OE, BERR_OE} !== 2'b10) begin
      bad++; $display("FAIL simul_ack_wins: got dt=%b be=%b want 1 0", DTACK_OE, BERR_OE);
    end
    bus_idle();
    tick();
    // ROM and EXP together: ROM timing (2 wait states).
    ASn = 1'b0; ROMSELn = 1'b0; EXPSELn = 1'b0;
    tick(); tick(); // k+1
    total++;
    if (DTACK_OE !== 1'b0) begin bad++; $display("FAIL multi_k+1: got %b want 0", DTACK_OE); end
    tick(); // k+2
    total++;
    if (DTACK_OE !== 1'b1) begin bad++; $display("FAIL multi_k+2: got %b want 1", DTACK_OE); end
    bus_idle();
    tick();
  endtask

  task automatic test_abort();
    ASn = 1'b0; EXPSELn = 1'b0;
    tick(); tick(); // k, k+1
    ASn = 1'b1;
    tick(); // k+2
    total++;
    if ({DTACK_OE, BUSY} !== 2'b00) begin
      bad++; $display("FAIL abort_k+2: got dt=%b busy=%b want 0 0", DTACK_OE, BUSY);
    end
    tick(); // k+3
    ASn = 1'b0;
    tick(); // k+4, new cycle
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL abort_restart_busy: got %b want 1", BUSY); end
    for (int e = 5; e <= 8; e++) begin
      tick();
      total++;
      if (DTACK_OE !== (e == 8)) begin
        bad++; $display("FAIL abort_fresh_k+%0d: got %b want %b", e, DTACK_OE, (e == 8));
      end
    end
    bus_idle();
    tick();
    total++;
    if (BERRCNT !== 8'(exp_cnt)) begin
      bad++; $display("FAIL abort_no_count: got %0d want %0d", BERRCNT, exp_cnt);
    end
  endtask

  task automatic test_unmapped(input int reps);
    for (int r = 0; r < reps; r++) begin
      int early = 0;
      ASn = 1'b0;
      for (int e = 0; e < 127; e++) begin
        tick();
        if (BERR_OE !== 1'b0 || DTACK_OE !== 1'b0) early++;
      end
      tick(); // k+127
      if (r == 0 || r == reps - 1) begin
        total++;
        if (early != 0 || {DTACK_OE, BERR_OE} !== 2'b01) begin
          bad++; $display("FAIL wd_berr rep%0d: got dt=%b be=%b early=%0d want 0 1 0",
                          r, DTACK_OE, BERR_OE, early);
        end
      end
      ASn = 1'b1;
      tick();
      if (exp_cnt < 255) exp_cnt++;
      total++;
      if (BERRCNT !== 8'(exp_cnt) || BERR_OE !== 1'b0) begin
        bad++; $display("FAIL wd_count rep%0d: got cnt=%0d be=%b want %0d 0",
                        r, BERRCNT, BERR_OE, exp_cnt);
      end
    end
  endtask

  initial begin
    HWRST = 1'b1;
    bus_idle();
    test_reset();
    test_ram();
    test_rom();
    test_io();
    test_iack();
    test_simultaneous();
    test_abort();
    test_unmapped(1);
    test_unmapped(256);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
